ram_batch_sequencer: RTL

//   Ring-buffer controller for the unidirectional triple-read-port sample RAM (RAM_triple) used by the batch filter.

---
 rtl/ram_batch_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ram_batch_sequencer.sv
// Ring-buffer write/sweep controller for the triple-read-port sample RAM.
// Streams samples in by batch and sweeps the three newest complete batches.
module ram_batch_sequencer #(
    parameter int DEPTH   = 32,
    parameter int D_WIDTH = 3,
    parameter int BATCH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [D_WIDTH-1:0]       in_data,
    output logic                     in_ready,
    output logic                     ram_write,
    output logic [$clog2(DEPTH)-1:0] ram_addrIn,
    output logic [D_WIDTH-1:0]       ram_dataIn,
    output logic [$clog2(DEPTH)-1:0] ram_addrOut1,
    output logic [$clog2(DEPTH)-1:0] ram_addrOut2,
    output logic [$clog2(DEPTH)-1:0] ram_addrOut3,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     rd_first,
    output logic                     rd_last
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(BATCH);

    typedef enum logic [1:0] {PRIME, IDLE, SWEEP} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] newest_base;
    logic [AW-1:0] b1, b1_nx;
    logic [AW-1:0] done_base;
    logic [BW-1:0] fill_cnt;
    logic [BW-1:0] beat, beat_nx;
    logic [1:0]    prime_cnt, prime_nx;
    logic          pending, pending_nx;
    logic          wr, done, adv, last, sweeping;

    assign in_ready  = ~pending;
    assign wr        = in_valid & ~pending & ~rst;
    assign done      = wr && (fill_cnt == BW'(BATCH - 1));
    assign done_base = wr_ptr - AW'(BATCH - 1);
    assign sweeping  = (state == SWEEP);
    assign adv       = sweeping && rd_ready;
    assign last      = adv && (beat == BW'(BATCH - 1));

    assign ram_write  = wr;
    assign ram_addrIn = wr_ptr;
    assign ram_dataIn = in_data;

    // A batch finishing while idle starts its sweep on the next cycle directly;
    // pending only holds a batch that finished while another sweep was busy.
    always_comb begin
        state_nx   = state;
        beat_nx    = beat;
        b1_nx      = b1;
        pending_nx = pending;
        prime_nx   = prime_cnt;
        unique case (state)
            PRIME: begin
                if (done) begin
                    if (prime_cnt == 2'd2) begin
                        state_nx = SWEEP;
                        beat_nx  = '0;
                        b1_nx    = done_base;
                    end else begin
                        prime_nx = prime_cnt + 2'd1;
                    end
                end
            end
            IDLE: begin
                if (pending) begin
                    state_nx   = SWEEP;
                    beat_nx    = '0;
                    b1_nx      = newest_base;
                    pending_nx = 1'b0;
                end else if (done) begin
                    state_nx = SWEEP;
                    beat_nx  = '0;
                    b1_nx    = done_base;
                end
            end
            SWEEP: begin
                if (last) begin
                    beat_nx = '0;
                    if (pending) begin
                        b1_nx      = newest_base;
                        pending_nx = 1'b0;
                    end else if (done) begin
                        b1_nx = done_base;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    if (adv) beat_nx = beat + BW'(1);
                    if (done) pending_nx = 1'b1;
                end
            end
            default: state_nx = PRIME;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= PRIME;
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            prime_cnt   <= '0;
            beat        <= '0;
            pending     <= 1'b0;
            newest_base <= '0;
            b1          <= '0;
        end else begin
            if (wr) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fill_cnt <= fill_cnt + BW'(1);
            end
            if (done) newest_base <= done_base;
            state     <= state_nx;
            beat      <= beat_nx;
            b1        <= b1_nx;
            pending   <= pending_nx;
            prime_cnt <= prime_nx;
        end
    end

    assign rd_valid     = sweeping;
    assign rd_first     = sweeping && (beat == '0);
    assign rd_last      = sweeping && (beat == BW'(BATCH - 1));
    assign ram_addrOut1 = sweeping ? b1 + AW'(BATCH - 1) - AW'(beat) : '0;
    assign ram_addrOut2 = sweeping ? b1 - AW'(BATCH) + AW'(beat) : '0;
    assign ram_addrOut3 = sweeping ? b1 - AW'(2 * BATCH) + AW'(beat) : '0;

endmodule
